// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, ROM prefetch addressing,
// confirm-button gating of IO-read instructions and sticky halt on illegal PC.
module ifetch_unit #(
    parameter int                   ISA_WIDTH       = 32,
    parameter int                   ADDRESS_WIDTH   = 26,
    parameter int                   IMEM_ADDR_WIDTH = 14,
    parameter logic [ISA_WIDTH-1:0] RESET_PC        = 'h0000_0000,
    parameter logic [ISA_WIDTH-1:0] PC_LIMIT        = 'h0001_0000,
    parameter int                   DEBOUNCE_CYCLES = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       Branch,
    input  logic                       nBranch,
    input  logic                       Jmp,
    input  logic                       Jal,
    input  logic                       Jr,
    input  logic                       Zero,
    input  logic [ISA_WIDTH-1:0]       Addr_result,
    input  logic [ISA_WIDTH-1:0]       Read_data_1,
    input  logic                       IORead,
    input  logic                       confirm_button,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [ISA_WIDTH-1:0]       imem_data,
    output logic [ISA_WIDTH-1:0]       Instruction,
    output logic [ISA_WIDTH-1:0]       pc,
    output logic [ISA_WIDTH-1:0]       branch_base_addr,
    output logic [ISA_WIDTH-1:0]       link_addr,
    output logic                       io_waiting,
    output logic                       halted,
    output logic [1:0]                 fault
);

    typedef enum logic [1:0] {
        ST_RUN          = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_WAIT_RELEASE = 2'd2,
        ST_HALT         = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ISA_WIDTH-1:0]   r_pc;
    logic [1:0]             r_fault;
    logic [1:0]             w_fault_next;
    logic                   r_btn_stable;
    logic                   r_btn_stable_d;
    logic                   w_press;

    logic [ISA_WIDTH-1:0]   w_instr;
    logic [ISA_WIDTH-1:0]   w_pc_plus4;
    logic [ISA_WIDTH-1:0]   w_jump_target;
    logic [ISA_WIDTH-1:0]   w_cand;
    logic [ISA_WIDTH-1:0]   w_next_pc;
    logic                   w_is_jump;
    logic                   w_taken;
    logic                   w_io_gate;
    logic                   w_hold;
    logic                   w_io_wait;

    // The filtered button only flips after the raw level disagrees for DEBOUNCE_CYCLES edges.
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_filter
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_btn_stable <= 1'b0;
                end else begin
                    r_btn_stable <= confirm_button;
                end
            end
        end else begin : g_filter
            localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            logic [CNT_W-1:0] r_db_cnt;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_db_cnt     <= '0;
                    r_btn_stable <= 1'b0;
                end else if (confirm_button == r_btn_stable) begin
                    r_db_cnt     <= '0;
                end else if (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db_cnt     <= '0;
                    r_btn_stable <= confirm_button;
                end else begin
                    r_db_cnt     <= r_db_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign w_press = r_btn_stable & ~r_btn_stable_d;

    assign w_instr       = (reset || r_state == ST_HALT) ? '0 : imem_data;
    assign w_pc_plus4    = r_pc + ISA_WIDTH'(4);
    assign w_jump_target = {w_pc_plus4[ISA_WIDTH-1:ADDRESS_WIDTH+2], w_instr[ADDRESS_WIDTH-1:0], 2'b00};
    assign w_is_jump     = Jmp | Jal;
    assign w_taken       = (Branch & Zero) | (nBranch & ~Zero);
    // A jump on an IO-read cycle takes priority, so it never enters a wait.
    assign w_io_gate     = IORead & ~w_is_jump;

    always_comb begin
        if (w_is_jump) begin
            w_cand = w_jump_target;
        end else if (w_taken) begin
            w_cand = Addr_result;
        end else if (Jr) begin
            w_cand = Read_data_1;
        end else begin
            w_cand = w_pc_plus4;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fault_next = r_fault;
        w_hold       = 1'b0;
        w_io_wait    = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_io_gate && !w_press) begin
                    w_hold       = 1'b1;
                    w_io_wait    = 1'b1;
                    w_state_next = ST_WAIT_PRESS;
                end else if (w_io_gate) begin
                    w_state_next = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_PRESS: begin
                if (w_press) begin
                    w_state_next = ST_WAIT_RELEASE;
                end else begin
                    w_hold    = 1'b1;
                    w_io_wait = 1'b1;
                end
            end
            ST_WAIT_RELEASE: begin
                if (w_io_gate) begin
                    w_hold    = 1'b1;
                    w_io_wait = 1'b1;
                end
                if (!r_btn_stable) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_hold = 1'b1;
            end
        endcase

        // Any PC that would actually be taken is vetted; the last legal PC is kept on a fault.
        if (!w_hold) begin
            if (w_cand >= PC_LIMIT) begin
                w_hold       = 1'b1;
                w_fault_next = 2'b01;
                w_state_next = ST_HALT;
            end else if (w_cand[1:0] != 2'b00) begin
                w_hold       = 1'b1;
                w_fault_next = 2'b10;
                w_state_next = ST_HALT;
            end
        end
    end

    assign w_next_pc = w_hold ? r_pc : w_cand;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_state        <= ST_RUN;
            r_fault        <= 2'b00;
            r_btn_stable_d <= 1'b0;
        end else begin
            r_pc           <= w_next_pc;
            r_state        <= w_state_next;
            r_fault        <= w_fault_next;
            r_btn_stable_d <= r_btn_stable;
        end
    end

    // Prefetch: the ROM registers the word of the PC about to be loaded.
    assign imem_addr        = reset ? RESET_PC[IMEM_ADDR_WIDTH+1:2] : w_next_pc[IMEM_ADDR_WIDTH+1:2];
    assign Instruction      = w_instr;
    assign pc               = r_pc;
    assign branch_base_addr = w_pc_plus4;
    assign link_addr        = w_pc_plus4;
    assign io_waiting       = w_io_wait & ~reset;
    assign halted           = (r_state == ST_HALT);
    assign fault            = r_fault;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: stimulus queues expected per-cycle state,
// a negedge monitor pops and compares against the DUT outputs.
module tb_ifetch_unit;

    localparam int DB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0, Zero = 1'b0;
    logic [31:0] Addr_result = '0, Read_data_1 = '0;
    logic        IORead = 1'b0, confirm_button = 1'b0;
    logic [13:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] Instruction, pc, branch_base_addr, link_addr;
    logic        io_waiting, halted;
    logic [1:0]  fault;

    ifetch_unit #(
        .ISA_WIDTH(32), .ADDRESS_WIDTH(26), .IMEM_ADDR_WIDTH(14),
        .RESET_PC(32'h0000_0000), .PC_LIMIT(32'h0001_0000), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock(clock), .reset(reset),
        .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr), .Zero(Zero),
        .Addr_result(Addr_result), .Read_data_1(Read_data_1),
        .IORead(IORead), .confirm_button(confirm_button),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .Instruction(Instruction), .pc(pc),
        .branch_base_addr(branch_base_addr), .link_addr(link_addr),
        .io_waiting(io_waiting), .halted(halted), .fault(fault)
    );

    always #5 clock = ~clock;

    logic [31:0] rom [0:16383];
    always @(posedge clock) imem_data <= rom[imem_addr];

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        iow;
        logic        halt;
        logic [1:0]  fault;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(input string tag, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, req);
        end
    endtask

    // Monitor: one popped expectation per cycle, compared away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() != 0) begin
                e = q.pop_front();
                $display("check %-22s pc=%h instr=%h iow=%0b halted=%0b fault=%b",
                         e.name, pc, Instruction, io_waiting, halted, fault);
                cmp(e.name, "pc", pc, e.pc);
                cmp(e.name, "instr", Instruction, e.instr);
                cmp(e.name, "link", link_addr, e.pc + 32'd4);
                cmp(e.name, "bbase", branch_base_addr, e.pc + 32'd4);
                cmp(e.name, "io_waiting", {31'd0, io_waiting}, {31'd0, e.iow});
                cmp(e.name, "halted", {31'd0, halted}, {31'd0, e.halt});
                cmp(e.name, "fault", {30'd0, fault}, {30'd0, e.fault});
            end
        end
    end

    function automatic logic [31:0] romw(input logic [31:0] p);
        return rom[p[15:2]];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_now(input string n, input logic [31:0] p, input logic [31:0] ins,
                              input logic w, input logic h, input logic [1:0] f);
        exp_t e;
        e.name = n; e.pc = p; e.instr = ins; e.iow = w; e.halt = h; e.fault = f;
        q.push_back(e);
    endtask

    task automatic run(input string n, input logic [31:0] p, input logic w);
        expect_now(n, p, romw(p), w, 1'b0, 2'b00);
        tick();
    endtask

    // Button high for DB filter cycles (still held) then the press cycle advances.
    task automatic press_seq(input string n, input logic [31:0] p);
        confirm_button = 1'b1;
        repeat (DB) run({n, "_filter"}, p, 1'b1);
        run({n, "_press"}, p, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = 32'h1000_0000 + i;
        rom[16'h40] = 32'h0C00_0020;   // at pc 0x100: jal, target field 0x20
        rom[16'h80] = 32'h0800_0008;   // at pc 0x200: j, target field 0x08

        repeat (2) tick();
        expect_now("reset", 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        tick();
        reset = 1'b0;

        // 1: sequential fetch
        run("t1_pc0", 32'h0, 1'b0);
        run("t1_pc4", 32'h4, 1'b0);
        run("t1_pc8", 32'h8, 1'b0);
        run("t1_pcC", 32'hC, 1'b0);

        // 2: branches
        Branch = 1'b1; Zero = 1'b1; Addr_result = 32'h40;
        run("t2_beq_taken", 32'h10, 1'b0);
        Branch = 1'b0; Jr = 1'b1; Read_data_1 = 32'h10;
        run("t2_jr_back", 32'h40, 1'b0);
        Jr = 1'b0; Branch = 1'b1; Zero = 1'b0;
        run("t2_beq_not", 32'h10, 1'b0);
        Branch = 1'b0; nBranch = 1'b1; Zero = 1'b0; Jr = 1'b1; Read_data_1 = 32'h300;
        run("t2_bne_over_jr", 32'h14, 1'b0);

        // 3: jal / jr / j-over-IORead
        nBranch = 1'b0; Jr = 1'b1; Read_data_1 = 32'h100;
        run("t3_jr_100", 32'h40, 1'b0);
        Jal = 1'b1; Read_data_1 = 32'h500;
        run("t3_jal", 32'h100, 1'b0);
        Jal = 1'b0; Read_data_1 = 32'h200;
        run("t3_jr_200", 32'h80, 1'b0);
        Jr = 1'b0; Jmp = 1'b1; IORead = 1'b1;
        run("t3_j_on_io", 32'h200, 1'b0);
        Jmp = 1'b0;

        // 4: IO wait, glitch rejection, one press per IORead
        run("t4_io_hold", 32'h20, 1'b1);
        repeat (2) run("t4_wait", 32'h20, 1'b1);
        confirm_button = 1'b1;
        repeat (2) run("t4_glitch", 32'h20, 1'b1);
        confirm_button = 1'b0;
        repeat (3) run("t4_wait_post_glitch", 32'h20, 1'b1);
        press_seq("t4_p1", 32'h20);
        run("t4_io2_btn_down", 32'h24, 1'b1);
        confirm_button = 1'b0;
        repeat (8) run("t4_io2_hold", 32'h24, 1'b1);
        press_seq("t4_p2", 32'h24);
        IORead = 1'b0;
        run("t4_nonio_adv", 32'h28, 1'b0);
        IORead = 1'b1; confirm_button = 1'b0;
        repeat (7) run("t4_io3_hold", 32'h2C, 1'b1);

        // 6: async reset while waiting for a press
        expect_now("t6_async_reset", 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        #3 reset = 1'b1;
        tick();
        IORead = 1'b0;
        expect_now("t6_reset_hold", 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        tick();
        reset = 1'b0;
        run("t6_resume0", 32'h0, 1'b0);
        run("t6_resume4", 32'h4, 1'b0);

        // 5: halts
        Jr = 1'b1; Read_data_1 = 32'h0001_0000;
        run("t5_jr_limit", 32'h8, 1'b0);
        expect_now("t5_halt01", 32'h8, 32'h0, 1'b0, 1'b1, 2'b01);
        tick();
        Read_data_1 = 32'h40;
        expect_now("t5_halt01_sticky", 32'h8, 32'h0, 1'b0, 1'b1, 2'b01);
        tick();
        reset = 1'b1; Jr = 1'b0;
        expect_now("t5_reset", 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        tick();
        reset = 1'b0;
        run("t5_after_reset", 32'h0, 1'b0);
        Jr = 1'b1; Read_data_1 = 32'h202;
        run("t5_jr_misalign", 32'h4, 1'b0);
        Jr = 1'b0;
        expect_now("t5_halt10", 32'h4, 32'h0, 1'b0, 1'b1, 2'b10);
        tick();
        expect_now("t5_halt10_sticky", 32'h4, 32'h0, 1'b0, 1'b1, 2'b10);
        tick();
        reset = 1'b1;
        expect_now("t5_reset2", 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        tick();
        reset = 1'b0;
        Jr = 1'b1; Read_data_1 = 32'hFFFC;
        run("t5_jr_last_word", 32'h0, 1'b0);
        Jr = 1'b0;
        run("t5_last_word", 32'hFFFC, 1'b0);
        expect_now("t5_seq_over_limit", 32'hFFFC, 32'h0, 1'b0, 1'b1, 2'b01);
        tick();

        repeat (2) @(negedge clock);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
